// File: rtl/des_subkey_sched_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 tables, shift schedule, state encoding
// and the PC-1 / half-rotate helpers used by the subkey scheduler.
package des_subkey_sched_pkg;

  localparam int KEY_W  = 64;
  localparam int SK_W   = 48;
  localparam int NROUND = 16;
  localparam int CD_W   = 56;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Tables use DES 1-based numbering where bit 1 is the MSB of the vector.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < CD_W; i++) begin
      r[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1_TBL[i])];
    end
    return r;
  endfunction

  // idx is the zero-based round index into the shift schedule.
  function automatic logic shift_is_two(input logic [3:0] idx);
    return SHIFT_TBL[idx] == 2;
  endfunction

  function automatic logic [CD_W-1:0] rotl_cd(input logic [CD_W-1:0] cd, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[25:0], c[27:26], d[25:0], d[27:26]};
    return {c[26:0], c[27], d[26:0], d[27]};
  endfunction

  function automatic logic [CD_W-1:0] rotr_cd(input logic [CD_W-1:0] cd, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[1:0], c[27:2], d[1:0], d[27:2]};
    return {c[0], c[27:1], d[0], d[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: selects the 48 subkey bits out of the 56-bit C/D register.
module des_pc2
  import des_subkey_sched_pkg::*;
(
  input  logic [CD_W-1:0] cd_i,
  output logic [SK_W-1:0] sk_o
);

  always_comb begin
    sk_o = '0;
    for (int i = 0; i < SK_W; i++) begin
      sk_o[6'(SK_W - 1 - i)] = cd_i[6'(CD_W - PC2_TBL[i])];
    end
  end

endmodule

// File: rtl/des_subkey_sched.sv
// Sequential DES key schedule: latches PC-1 of a key and streams the 16 round subkeys
// over a valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_subkey_sched
  import des_subkey_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             decrypt,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [SK_W-1:0]  sk_out,
  output logic [3:0]       sk_idx,
  output logic             sk_valid,
  input  logic             sk_ready,
  output logic             done
);

  localparam logic [3:0] LAST_CNT = 4'(NROUND - 1);

  state_e          state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            sk_valid_q, sk_valid_d;
  logic            done_q, done_d;

  logic            key_hs;
  logic            sk_hs;
  logic            last;
  logic [CD_W-1:0] key_pc1;

  assign key_ready = (state_q == ST_IDLE);
  assign key_hs    = key_valid & key_ready;
  assign sk_hs     = sk_valid_q & sk_ready;
  assign last      = (cnt_q == LAST_CNT);
  assign key_pc1   = pc1(key_in);

  // Decrypt starts from C0D0 because the full schedule rotates each half by 28, i.e. C16D16 == C0D0.
  always_comb begin
    state_d    = state_q;
    cd_d       = cd_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    sk_valid_d = sk_valid_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_hs) begin
          mode_d     = decrypt;
          cnt_d      = '0;
          state_d    = ST_RUN;
          sk_valid_d = 1'b1;
          cd_d       = decrypt ? key_pc1 : rotl_cd(key_pc1, 1'b0);
        end
      end
      ST_RUN: begin
        if (sk_hs) begin
          cnt_d = cnt_q + 4'd1;
          if (mode_q) begin
            cd_d = rotr_cd(cd_q, shift_is_two(LAST_CNT - cnt_q));
          end else if (!last) begin
            cd_d = rotl_cd(cd_q, shift_is_two(cnt_q + 4'd1));
          end
          if (last) begin
            state_d    = ST_FIN;
            sk_valid_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        sk_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cd_q       <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      sk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cd_q       <= cd_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      sk_valid_q <= sk_valid_d;
      done_q     <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i (cd_q),
    .sk_o (sk_out)
  );

  assign sk_valid = sk_valid_q;
  assign done     = done_q;
  assign sk_idx   = mode_q ? (LAST_CNT - cnt_q) : cnt_q;

endmodule
